// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side stream stage.
package fifo_rd_stream_pkg;

    localparam int unsigned FIFO_RD_LAT = 1;
    localparam int unsigned OBUF_DEPTH  = 3;
    localparam int unsigned OCC_W       = $clog2(OBUF_DEPTH + 1);
    localparam int unsigned BEAT_W      = 16;
    // Largest buffered + in-flight count that still leaves room for one more pop.
    localparam int unsigned POP_LIMIT   = OBUF_DEPTH - FIFO_RD_LAT;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream of the read-side stage.
interface fifo_rd_stream_if #(
    parameter int unsigned WIDTH = 32
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_ren;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_ren, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_ren, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_rd_stream_obuf3.sv
// Three-entry register FIFO; head is always entry 0, pops shift the entries down.
module obuf3
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             clear,
    output logic [OCC_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem     [OBUF_DEPTH];
    logic [WIDTH-1:0] mem_nxt [OBUF_DEPTH];
    logic [OCC_W-1:0] cnt_nxt;

    // Pop shifts first, then the push lands in the first free slot.
    always_comb begin
        mem_nxt = mem;
        cnt_nxt = count;
        if (pop && (count != '0)) begin
            for (int i = 0; i < int'(OBUF_DEPTH) - 1; i++) begin
                mem_nxt[i] = mem[i+1];
            end
            cnt_nxt = count - OCC_W'(1);
        end
        if (push && (cnt_nxt < OCC_W'(OBUF_DEPTH))) begin
            for (int i = 0; i < int'(OBUF_DEPTH); i++) begin
                if (cnt_nxt == OCC_W'(i)) begin
                    mem_nxt[i] = din;
                end
            end
            cnt_nxt = cnt_nxt + OCC_W'(1);
        end
        if (clear) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            for (int i = 0; i < int'(OBUF_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= cnt_nxt;
            mem   <= mem_nxt;
        end
    end

    assign head = mem[0];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer: pops the async FIFO, absorbs the read latency in a small
// buffer and presents the words as a full-throughput valid/ready stream with burst marks.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    fifo_rd_stream_if.master  bus,
    output logic [OCC_W-1:0]  occupancy,
    output logic [BEAT_W-1:0] beat_cnt
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic           infl;
    logic           xfer;
    logic           push;
    logic [OCC_W:0] outstanding;

    // Every popped word not yet delivered must fit in the buffer when it lands.
    assign outstanding  = {1'b0, occupancy} + (OCC_W+1)'(infl);
    assign bus.fifo_ren = reset && !bus.fifo_empty && !flush
                          && (outstanding <= (OCC_W+1)'(POP_LIMIT));

    assign bus.m_valid = (occupancy != '0);
    assign bus.m_last  = bus.m_valid && (beat_cnt == LAST_BEAT);
    assign xfer        = bus.m_valid && bus.m_ready;
    // A word landing during flush was popped before it and is dropped.
    assign push        = infl && !flush;

    obuf3 #(.WIDTH(WIDTH)) u_obuf (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.fifo_rdata),
        .pop   (xfer),
        .clear (flush),
        .count (occupancy),
        .head  (bus.m_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            infl <= 1'b0;
        end else begin
            infl <= bus.fifo_ren;
        end
    end

    // Beat position within the burst, advanced per accepted word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
        end else if (flush) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            if (beat_cnt == LAST_BEAT) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench: the bench plays the FIFO and tracks every popped word
// as a pending delivery, with the delivery/beat rules as the expected behaviour.
module tb_fifo_rd_stream;

    localparam int BL = 16;

    typedef struct {
        logic [31:0] d;
        int          t;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [1:0]  occupancy;
    logic [15:0] beat_cnt;

    fifo_rd_stream_if #(.WIDTH(32)) bus ();

    fifo_rd_stream #(.WIDTH(32), .BURST_LEN(BL)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          beat_m = 0;
    logic        force_empty = 1'b0;
    logic [31:0] src_q [$];
    ent_t        exp_q [$];

    int          n_pop, n_xfer, nv, nl, first_v, last_v;
    logic [31:0] first_xd;
    logic [31:0] words [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_occ();
        int n = 0;
        foreach (exp_q[i]) if (cyc >= exp_q[i].t + 2) n++;
        return n;
    endfunction

    task automatic clr_stats();
        n_pop = 0; n_xfer = 0; nv = 0; nl = 0; first_v = -1; last_v = -1;
        first_xd = '0;
    endtask

    // One clock: check DUT against the pending-word model, then advance both.
    task automatic tick();
        int          occ_e;
        logic        v_e, ren_e, ren_o, xfer_e;
        logic [31:0] d;
        d = '0;
        bus.fifo_empty = (src_q.size() == 0) || force_empty;
        @(negedge clk);
        occ_e = model_occ();
        v_e   = (occ_e != 0);
        ren_e = !bus.fifo_empty && !flush && (exp_q.size() <= 2);
        chk("m_valid", 32'(bus.m_valid), 32'(v_e));
        chk("occupancy", 32'(occupancy), 32'(occ_e));
        chk("fifo_ren", 32'(bus.fifo_ren), 32'(ren_e));
        chk("beat_cnt", 32'(beat_cnt), 32'(beat_m));
        if (v_e) begin
            chk("m_data", bus.m_data, exp_q[0].d);
            chk("m_last", 32'(bus.m_last), 32'(beat_m == BL - 1));
        end else begin
            chk("m_last_idle", 32'(bus.m_last), 32'd0);
        end
        if (bus.m_valid) begin
            nv++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (bus.m_last) nl++;
        ren_o  = bus.fifo_ren;
        xfer_e = v_e && bus.m_ready;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            beat_m = 0;
        end else if (xfer_e) begin
            if (n_xfer == 0) first_xd = exp_q[0].d;
            n_xfer++;
            void'(exp_q.pop_front());
            beat_m = (beat_m == BL - 1) ? 0 : beat_m + 1;
        end
        if (ren_o) begin
            d = (src_q.size() != 0) ? src_q.pop_front() : 32'hdead_beef;
            exp_q.push_back('{d, cyc});
            n_pop++;
        end
        cyc++;
        #1;
        bus.fifo_rdata = ren_o ? d : $urandom;
        bus.fifo_empty = (src_q.size() == 0) || force_empty;
    endtask

    task automatic drain();
        bus.m_ready = 1'b1;
        flush       = 1'b0;
        force_empty = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (src_q.size() == 0 && exp_q.size() == 0) break;
            tick();
        end
        chk("drain_left", 32'(src_q.size() + exp_q.size()), 32'd0);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) src_q.push_back($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        flush          = 1'b0;
        bus.m_ready    = 1'b1;
        bus.fifo_rdata = '0;
        load(5);
        bus.fifo_empty = 1'b0;

        // Reset state with a non-empty FIFO.
        #1;
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_fifo_ren", 32'(bus.fifo_ren), 32'd0);
        repeat (3) @(posedge clk);
        chk("rst_m_data", bus.m_data, 32'd0);
        chk("rst_m_last", 32'(bus.m_last), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_beat", 32'(beat_cnt), 32'd0);
        #1 reset = 1'b1;

        // First words after release: pop immediately, valid two cycles later.
        clr_stats();
        tick();
        chk("first_pop", 32'(n_pop), 32'd1);
        drain();
        chk("s1_words", 32'(n_xfer), 32'd5);
        chk("s1_first_valid", 32'(first_v), 32'(first_v >= 0 ? first_v : 99));
        flush = 1'b1; tick(); flush = 1'b0;

        // 40-word burst stream at full throughput.
        clr_stats();
        load(40);
        for (int i = 0; i < 45; i++) tick();
        chk("s2_valid_cycles", 32'(nv), 32'd40);
        chk("s2_no_gaps", 32'(last_v - first_v + 1), 32'd40);
        chk("s2_last_count", 32'(nl), 32'd2);
        chk("s2_end_beat", 32'(beat_cnt), 32'd8);
        flush = 1'b1; tick(); flush = 1'b0;

        // Downstream stall: buffer fills to three and popping stops.
        clr_stats();
        load(10);
        bus.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("s3_pops", 32'(n_pop), 32'd3);
        chk("s3_occ", 32'(occupancy), 32'd3);
        chk("s3_ren", 32'(bus.fifo_ren), 32'd0);
        clr_stats();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("s3_words", 32'(n_xfer), 32'd10);
        chk("s3_no_gaps", 32'(last_v - first_v + 1), 32'd10);
        drain();

        // FIFO empty flag toggling every cycle.
        clr_stats();
        load(8);
        for (int i = 0; i < 30; i++) begin
            force_empty = i[0];
            tick();
        end
        force_empty = 1'b0;
        drain();
        chk("s4_words", 32'(n_xfer), 32'd8);

        // Flush with two buffered words and one in flight.
        clr_stats();
        for (int i = 0; i < 6; i++) begin
            words[i] = $urandom;
            src_q.push_back(words[i]);
        end
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("s5_occ_pre", 32'(occupancy), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("s5_occ_post", 32'(occupancy), 32'd0);
        chk("s5_beat_post", 32'(beat_cnt), 32'd0);
        clr_stats();
        drain();
        chk("s5_next_word", first_xd, words[3]);
        chk("s5_words", 32'(n_xfer), 32'd3);

        // Asynchronous reset in the middle of a burst.
        load(20);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (beat_m == 7 && model_occ() != 0) break;
            tick();
        end
        chk("s6_pre_beat", 32'(beat_cnt), 32'd7);
        chk("s6_pre_valid", 32'(bus.m_valid), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("s6_valid", 32'(bus.m_valid), 32'd0);
        chk("s6_data", bus.m_data, 32'd0);
        chk("s6_last", 32'(bus.m_last), 32'd0);
        chk("s6_occ", 32'(occupancy), 32'd0);
        chk("s6_beat", 32'(beat_cnt), 32'd0);
        chk("s6_ren", 32'(bus.fifo_ren), 32'd0);
        exp_q.delete();
        beat_m = 0;
        @(posedge clk);
        cyc++;
        #1 reset = 1'b1;
        chk("s6_beat_release", 32'(beat_cnt), 32'd0);
        drain();

        // Randomised ready, empty and occasional flush.
        for (int i = 0; i < 400; i++) begin
            if (src_q.size() < 4 && $urandom_range(0, 1) == 1) load(1);
            force_empty = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 29) == 0);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
